nn_sched: RTL and testbench

- Scheduler that shares one NN datapath instance between two requesters.
- Each requester presents an operand pair through a valid/ready handshake; the block grants round-robin and drives NN enable/inputs for a fixed latency.
- It captures final_output, total_ovf and total_zero, and returns them tagged with the requester id.
- Sits between the system front-end and the NN core; one operation in flight at a time.

---
 rtl/nn_sched_pkg.sv | 19 +
 rtl/nn_rr_arb2.sv | 32 +++
 rtl/nn_sched.sv | 119 +++++++++++
 tb/tb_nn_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_sched_pkg.sv
// Shared constants for the NN scheduler: state encodings, default sizing, stats width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int DEF_DATAWIDTH  = 32;
  localparam int DEF_NN_LATENCY = 12;
  localparam int STAT_W         = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nn_rr_arb2.sv
// Two-way round-robin arbiter; the last_grant register remembers the previous winner.
// Latency: grant is combinational from req; last_grant updates on the advance edge.
// Backpressure: none; the caller asserts advance only when a grant is consumed.
module nn_rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 after reset so requester 0 wins the first contested grant.
  logic last_grant;

  // Single requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner each time a grant is actually taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
  end

endmodule

// File: rtl/nn_sched.sv
// Shares one NN datapath between two valid/ready requesters, round-robin, one op in flight.
// Latency: resp_valid rises NN_LATENCY edges after the accepting edge; at least one IDLE cycle between ops.
// Backpressure: resp_ready low holds RESP indefinitely, and no requester is ready meanwhile.
// Optional: define NN_SCHED_STATS_EN to add saturating done_cnt / ovf_cnt outputs.
module nn_sched
  import nn_sched_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int NN_LATENCY = DEF_NN_LATENCY   // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATAWIDTH-1:0] req0_in1,
  input  logic [DATAWIDTH-1:0] req0_in2,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATAWIDTH-1:0] req1_in1,
  input  logic [DATAWIDTH-1:0] req1_in2,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [DATAWIDTH-1:0] resp_data,
  output logic                 resp_ovf,
  output logic                 resp_zero,
  output logic                 nn_enable,
  output logic [DATAWIDTH-1:0] nn_input_1,
  output logic [DATAWIDTH-1:0] nn_input_2,
  input  logic [DATAWIDTH-1:0] nn_final_output,
  input  logic                 nn_total_ovf,
  input  logic                 nn_total_zero,
  output logic                 busy
`ifdef NN_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]    done_cnt,
  output logic [STAT_W-1:0]    ovf_cnt
`endif
);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [1:0] grant;
  logic       idle;
  logic       accept;
  logic       resp_hs;

  assign idle    = (state == S_IDLE);
  // Reset gating keeps ready low while resetn is asserted, even with a valid pending.
  assign req0_ready = resetn & idle & grant[0] & req0_valid;
  assign req1_ready = resetn & idle & grant[1] & req1_valid;
  assign accept     = req0_ready | req1_ready;
  assign resp_hs    = resp_valid & resp_ready;

  assign nn_enable  = (state == S_RUN);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  nn_rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  // Control FSM: accept and latch operands, count down the NN latency, capture, wait for handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_ovf   <= 1'b0;
      resp_zero  <= 1'b0;
      nn_input_1 <= '0;
      nn_input_2 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            nn_input_1 <= grant[1] ? req1_in1 : req0_in1;
            nn_input_2 <= grant[1] ? req1_in2 : req0_in2;
            resp_id    <= grant[1];
            cnt        <= 8'(NN_LATENCY);
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            resp_data <= nn_final_output;
            resp_ovf  <= nn_total_ovf;
            resp_zero <= nn_total_zero;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NN_SCHED_STATS_EN
  // Completed-response statistics, saturating rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (resp_hs) begin
      done_cnt <= sat_inc(done_cnt);
      if (resp_ovf) ovf_cnt <= sat_inc(ovf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_nn_sched.sv
// Directed bench for nn_sched with a latency-accurate NN stand-in (add with overflow/zero flags).
// Latency: model output is garbage until the NN has been enabled NN_LATENCY-1 edges.
// Backpressure: bench drives resp_ready, including a long stall.
module tb_nn_sched;

  localparam int DW  = 32;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic          resp_valid, resp_ready, resp_id, resp_ovf, resp_zero;
  logic [DW-1:0] resp_data;
  logic          nn_enable;
  logic [DW-1:0] nn_input_1, nn_input_2, nn_final_output;
  logic          nn_total_ovf, nn_total_zero;
  logic          busy;
`ifdef NN_SCHED_STATS_EN
  logic [15:0]   done_cnt, ovf_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nn_sched #(.DATAWIDTH(DW), .NN_LATENCY(LAT)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_in1        (req0_in1),
    .req0_in2        (req0_in2),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_in1        (req1_in1),
    .req1_in2        (req1_in2),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_data       (resp_data),
    .resp_ovf        (resp_ovf),
    .resp_zero       (resp_zero),
    .nn_enable       (nn_enable),
    .nn_input_1      (nn_input_1),
    .nn_input_2      (nn_input_2),
    .nn_final_output (nn_final_output),
    .nn_total_ovf    (nn_total_ovf),
    .nn_total_zero   (nn_total_zero),
    .busy            (busy)
`ifdef NN_SCHED_STATS_EN
    ,
    .done_cnt        (done_cnt),
    .ovf_cnt         (ovf_cnt)
`endif
  );

  // Reference NN: {ovf, zero, sum} of a signed 32-bit add.
  function automatic logic [33:0] nn_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic        o;
    s = a + b;
    o = (a[31] == b[31]) && (s[31] != a[31]);
    return {o, (s == 32'd0), s};
  endfunction

  // Count consecutive enabled edges so the NN output only becomes valid after the full latency.
  int en_cnt = 0;
  always @(posedge clk) en_cnt <= nn_enable ? en_cnt + 1 : 0;

  logic [33:0] nn_m;
  always_comb begin
    nn_m = nn_model(nn_input_1, nn_input_2);
    if (en_cnt >= LAT - 1) begin
      nn_final_output = nn_m[31:0];
      nn_total_ovf    = nn_m[33];
      nn_total_zero   = nn_m[32];
    end else begin
      nn_final_output = 32'hDEADBEEF;
      nn_total_ovf    = 1'b0;
      nn_total_zero   = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: valids already set at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic run_op(input string tag, input logic exp_id, input logic [31:0] a,
                        input logic [31:0] b, input int stall, input logic drop);
    int          edges;
    int          en_seen;
    logic [33:0] m;
    m = nn_model(a, b);
    #1;
    check({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    if (drop) begin
      if (exp_id) req1_valid = 1'b0;
      else        req0_valid = 1'b0;
    end
    @(negedge clk);
    edges   = 0;
    en_seen = 0;
    while (!resp_valid && edges < 100) begin
      en_seen += int'(nn_enable);
      @(negedge clk);
      edges++;
    end
    check({tag, "_lat"},  edges,   LAT);
    check({tag, "_en"},   en_seen, LAT);
    check({tag, "_id"},   resp_id, exp_id);
    check({tag, "_data"}, resp_data, m[31:0]);
    check({tag, "_ovf"},  resp_ovf,  m[33]);
    check({tag, "_zero"}, resp_zero, m[32]);
    check({tag, "_resp_rdyblk"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_data"}, resp_data, m[31:0]);
      check({tag, "_stall_flags"}, {27'd0, resp_valid, busy, resp_ovf, req1_ready, req0_ready},
            {27'd0, 1'b1, 1'b1, m[33], 1'b0, 1'b0});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, resp_valid}, 32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_in1   = '0;
    req0_in2   = '0;
    req1_in1   = '0;
    req1_in2   = '0;
    resp_ready = 1'b0;

    // Reset state, with a valid pending to show ready stays low.
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("rst_rdy0",   req0_ready, 1'b0);
    check("rst_busy",   busy, 1'b0);
    check("rst_en",     nn_enable, 1'b0);
    check("rst_rv",     resp_valid, 1'b0);
    check("rst_in1",    nn_input_1, 32'd0);
    check("rst_data",   resp_data, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Single requester 0 op.
    @(negedge clk);
    req0_valid = 1'b1; req0_in1 = 32'd5; req0_in2 = -32'sd3;
    run_op("op0", 1'b0, 32'd5, -32'sd3, 0, 1'b1);

    // Zero result.
    req0_valid = 1'b1; req0_in1 = 32'd7; req0_in2 = -32'sd7;
    run_op("zero", 1'b0, 32'd7, -32'sd7, 0, 1'b1);

    // Both valid, last winner was 0 -> 1 wins; overflow with 20-cycle response stall.
    req0_valid = 1'b1; req0_in1 = 32'd10; req0_in2 = 32'd20;
    req1_valid = 1'b1; req1_in1 = 32'd2000000000; req1_in2 = 32'd2000000000;
    run_op("ovf", 1'b1, 32'd2000000000, 32'd2000000000, 20, 1'b0);

    // Fairness with both held valid: 0,1,0,1.
    req1_in1 = -32'sd100; req1_in2 = -32'sd200;
    run_op("fair0", 1'b0, 32'd10, 32'd20, 0, 1'b0);
    run_op("fair1", 1'b1, -32'sd100, -32'sd200, 0, 1'b0);
    run_op("fair2", 1'b0, 32'd10, 32'd20, 0, 1'b0);
    run_op("fair3", 1'b1, -32'sd100, -32'sd200, 0, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Requester 0 alone, then reset in the 5th RUN cycle.
    @(negedge clk);
    req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd1;
    #1;
    check("mid_rdy0", req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run", {30'd0, busy, nn_enable}, 32'd3);
    resetn = 1'b0;
    #1;
    check("mid_rst", {29'd0, busy, nn_enable, resp_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // last_grant back to 1 -> requester 0 wins despite having been served last.
    @(negedge clk);
    req0_valid = 1'b1; req0_in1 = 32'd3; req0_in2 = 32'd4;
    req1_valid = 1'b1; req1_in1 = 32'd8; req1_in2 = 32'd9;
    run_op("post0", 1'b0, 32'd3, 32'd4, 0, 1'b1);
    run_op("post1", 1'b1, 32'd8, 32'd9, 0, 1'b1);

`ifdef NN_SCHED_STATS_EN
    check("stat_done", done_cnt, 32'd2);
    check("stat_ovf",  ovf_cnt,  32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
